// File: rtl/pio_edge_irq_pkg.sv
// Shared constants for the edge-capturing input PIO: register map and reset values.
// Debounce is selected at build time with PIO_EDGE_IRQ_DEBOUNCE_EN.
package pio_edge_irq_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA         = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN      = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK     = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_CAPTURE = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN      = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_PEND     = 3'd5;

    // Rising edges are enabled out of reset so a bare instance behaves like the legacy PIO.
    localparam logic [31:0] RISE_EN_RST = 32'hFFFF_FFFF;
    localparam logic [31:0] FALL_EN_RST = 32'h0000_0000;

endpackage

// File: rtl/pio_edge_irq_filter.sv
// One input channel: multi-flop synchroniser followed by an optional debounce filter.
// Debounce is compiled in only when PIO_EDGE_IRQ_DEBOUNCE_EN is defined.
module pio_edge_irq_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic stable
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_bit};
        end
    end

    assign sync_out = sync_reg[SYNC_STAGES-1];

`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             stable_reg;

    // The counter is cleared on the loading mismatch, so it never reaches past CNT_MAX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
        end else if (sync_out == stable_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_MAX) begin
            stable_reg <= sync_out;
            cnt_reg    <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign stable = stable_reg;
`else
    assign stable = sync_out;
`endif

endmodule

// File: rtl/pio_edge_irq_in.sv
// Avalon-MM input PIO with per-bit rise/fall edge capture and a masked level interrupt.
// Build with PIO_EDGE_IRQ_DEBOUNCE_EN to insert a debounce filter on every channel.
module pio_edge_irq_in
    import pio_edge_irq_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] rise_en_reg;
    logic [WIDTH-1:0] fall_en_reg;
    logic [WIDTH-1:0] irq_mask_reg;
    logic [WIDTH-1:0] edge_capture_reg;
    logic [WIDTH-1:0] edge_capture_next;
    logic [WIDTH-1:0] clear_mask;
    logic [WIDTH-1:0] wdata_w;
    logic [31:0]      readdata_reg;
    logic [31:0]      readdata_next;
    logic             wr_en;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            pio_edge_irq_filter #(
                .SYNC_STAGES(SYNC_STAGES),
                .DB_CYCLES  (DB_CYCLES)
            ) u_filter (
                .clk    (clk),
                .reset_n(reset_n),
                .in_bit (in_port[gi]),
                .stable (stable[gi])
            );
        end

        if (WIDTH < 32) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    assign wr_en   = chipselect && !write_n;
    assign wdata_w = writedata[WIDTH-1:0];

    assign edge_det = (stable & ~prev_reg & rise_en_reg) | (~stable & prev_reg & fall_en_reg);

    // OR-ing the new edges in after the W1C clear means a same-cycle event is never lost.
    always_comb begin
        clear_mask = '0;
        if (wr_en && address == ADDR_EDGE_CAPTURE) begin
            clear_mask = wdata_w;
        end
        edge_capture_next = (edge_capture_reg & ~clear_mask) | edge_det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg         <= '0;
            rise_en_reg      <= RISE_EN_RST[WIDTH-1:0];
            fall_en_reg      <= FALL_EN_RST[WIDTH-1:0];
            irq_mask_reg     <= '0;
            edge_capture_reg <= '0;
        end else begin
            prev_reg         <= stable;
            edge_capture_reg <= edge_capture_next;
            if (wr_en) begin
                case (address)
                    ADDR_RISE_EN:  rise_en_reg  <= wdata_w;
                    ADDR_IRQ_MASK: irq_mask_reg <= wdata_w;
                    ADDR_FALL_EN:  fall_en_reg  <= wdata_w;
                    default:       ;
                endcase
            end
        end
    end

    always_comb begin
        readdata_next = '0;
        case (address)
            ADDR_DATA:         readdata_next[WIDTH-1:0] = stable;
            ADDR_RISE_EN:      readdata_next[WIDTH-1:0] = rise_en_reg;
            ADDR_IRQ_MASK:     readdata_next[WIDTH-1:0] = irq_mask_reg;
            ADDR_EDGE_CAPTURE: readdata_next[WIDTH-1:0] = edge_capture_reg;
            ADDR_FALL_EN:      readdata_next[WIDTH-1:0] = fall_en_reg;
            ADDR_IRQ_PEND:     readdata_next[WIDTH-1:0] = edge_capture_reg & irq_mask_reg;
            default:           readdata_next = '0;
        endcase
    end

    // Read data is sampled every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_reg <= '0;
        end else begin
            readdata_reg <= readdata_next;
        end
    end

    assign readdata = readdata_reg;
    assign irq      = |(edge_capture_reg & irq_mask_reg);

endmodule

// File: tb/tb_pio_edge_irq_in.sv
// Self-checking bench for pio_edge_irq_in: a 4-bit and a 32-bit instance on a shared bus.
// Expected latencies follow PIO_EDGE_IRQ_DEBOUNCE_EN when it is defined for the build.
module tb_pio_edge_irq_in;

`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
    localparam int DBL = 4;
`else
    localparam int DBL = 0;
`endif
    localparam int LAT = 2 + DBL + 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        cs4 = 1'b0;
    logic        cs32 = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [3:0]  in4 = '0;
    logic [31:0] in32 = '0;
    logic [31:0] rd4, rd32;
    logic        irq4, irq32;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    pio_edge_irq_in #(.WIDTH(4), .SYNC_STAGES(2), .DB_CYCLES(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs4),
        .write_n(write_n), .writedata(writedata), .in_port(in4),
        .readdata(rd4), .irq(irq4)
    );

    pio_edge_irq_in #(.WIDTH(32), .SYNC_STAGES(2), .DB_CYCLES(4)) dut32 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs32),
        .write_n(write_n), .writedata(writedata), .in_port(in32),
        .readdata(rd32), .irq(irq32)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int sel, input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        cs4       = (sel == 0);
        cs32      = (sel == 1);
        write_n   = 1'b0;
        tick();
        cs4     = 1'b0;
        cs32    = 1'b0;
        write_n = 1'b1;
        $display("wr  dut%0d addr %0d data 0x%08h", sel == 0 ? 4 : 32, a, d);
    endtask

    task automatic rd(input int sel, input logic [2:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] got;
        logic [31:0] want;
        address = a;
        exp_q.push_back(exp);
        tick();
        got  = (sel == 0) ? rd4 : rd32;
        want = exp_q.pop_front();
        $display("rd  dut%0d addr %0d data 0x%08h (%s)", sel == 0 ? 4 : 32, a, got, tag);
        check(tag, got, want);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        tick(3);
        reset_n = 1'b1;

        // Reset values
        check("irq_reset", {31'b0, irq4}, 32'h0);
        rd(0, 3'd0, 32'h0, "rst_data");
        rd(0, 3'd1, 32'hF, "rst_rise_en");
        rd(0, 3'd2, 32'h0, "rst_mask");
        rd(0, 3'd3, 32'h0, "rst_capture");
        rd(0, 3'd4, 32'h0, "rst_fall_en");
        rd(0, 3'd5, 32'h0, "rst_pend");
        rd(1, 3'd1, 32'hFFFF_FFFF, "rst_rise_en32");

`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
        // A 3-cycle glitch must not survive a 4-cycle debounce
        in4[1] = 1'b1;
        tick(3);
        in4[1] = 1'b0;
        tick(LAT + 2);
        rd(0, 3'd3, 32'h0, "glitch_no_capture");
`endif

        // Rising edge latency on bit 1
        address = 3'd3;
        in4[1]  = 1'b1;
        tick(LAT - 1);
        rd(0, 3'd3, 32'h0, "rise_before_lat");
        rd(0, 3'd3, 32'h2, "rise_at_lat");
        rd(0, 3'd0, 32'h2, "data_bit1");
        check("irq_unmasked", {31'b0, irq4}, 32'h0);
        wr(0, 3'd2, 32'h2);
        check("irq_masked_on", {31'b0, irq4}, 32'h1);

        // Falling-only on bit 0
        wr(0, 3'd2, 32'h0);
        wr(0, 3'd3, 32'h2);
        wr(0, 3'd4, 32'h1);
        wr(0, 3'd1, 32'h0);
        in4[0] = 1'b1;
        tick(LAT);
        rd(0, 3'd3, 32'h0, "rise_ignored");
        in4[0] = 1'b0;
        tick(LAT);
        rd(0, 3'd3, 32'h1, "fall_captured");

        // Both edges on bit 3
        wr(0, 3'd1, 32'h8);
        wr(0, 3'd4, 32'h8);
        wr(0, 3'd3, 32'hF);
        in4[3] = 1'b1;
        tick(LAT);
        rd(0, 3'd3, 32'h8, "both_rise");
        wr(0, 3'd3, 32'h8);
        rd(0, 3'd3, 32'h0, "both_cleared");
        in4[3] = 1'b0;
        tick(LAT);
        rd(0, 3'd3, 32'h8, "both_fall");

        // Partial W1C and irq release
        wr(0, 3'd1, 32'hF);
        wr(0, 3'd4, 32'hF);
        wr(0, 3'd3, 32'hF);
        in4 = in4 ^ 4'hF;
        tick(LAT);
        rd(0, 3'd3, 32'hF, "all_captured");
        wr(0, 3'd2, 32'hF);
        check("irq_all", {31'b0, irq4}, 32'h1);
        wr(0, 3'd3, 32'h5);
        rd(0, 3'd3, 32'hA, "w1c_partial");
        rd(0, 3'd5, 32'hA, "pend_partial");
        check("irq_partial", {31'b0, irq4}, 32'h1);
        wr(0, 3'd3, 32'hA);
        check("irq_released", {31'b0, irq4}, 32'h0);

        // W1C of bit 2 on the very edge that sets it
        in4[2] = ~in4[2];
        tick(LAT - 1);
        wr(0, 3'd3, 32'h4);
        rd(0, 3'd3, 32'h4, "set_beats_clear");
        check("irq_collision", {31'b0, irq4}, 32'h1);

        // Bits above WIDTH are ignored and read 0
        wr(0, 3'd1, 32'hFFFF_FFF0);
        rd(0, 3'd1, 32'h0, "rise_en_hi_bits");
        rd(0, 3'd6, 32'h0, "addr6_dut4");

        // 32-bit instance, all channels together
        address = 3'd3;
        in32    = 32'hFFFF_FFFF;
        tick(LAT - 1);
        rd(1, 3'd3, 32'h0, "w32_before_lat");
        rd(1, 3'd3, 32'hFFFF_FFFF, "w32_all");
        wr(1, 3'd6, 32'h1234_5678);
        rd(1, 3'd6, 32'h0, "w32_addr6");
        check("irq32_unmasked", {31'b0, irq32}, 32'h0);
        wr(1, 3'd2, 32'h8000_0000);
        check("irq32_msb", {31'b0, irq32}, 32'h1);
        rd(1, 3'd5, 32'h8000_0000, "w32_pend");

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pio_edge_irq_in.md
# pio_edge_irq_in

Parametrised Avalon-MM input port with synchronisation, optional debounce, per-bit rising/falling edge selection, edge capture and a masked level interrupt. It is the next generation of the system's push-button/switch input PIO. It sits between board-level inputs (keys, switches, external strobes) and the Qsys interconnect, with `irq` routed to the processor interrupt controller.

## Interface
- `WIDTH`, 4 — number of input channels, 1..32.
- `SYNC_STAGES`, 2 — synchroniser flops per channel, minimum 2.
- `DB_CYCLES`, 16 — consecutive stable cycles required by the debounce filter, minimum 1. Used only when debounce is compiled in.
- `clk` in 1 — system clock.
- `reset_n` in 1 — reset, asynchronous, active-low.
- `address` in 3 — register word address.
- `chipselect` in 1 — slave select.
- `write_n` in 1 — active-low write strobe.
- `writedata` in 32 — write data. Bits at or above WIDTH are ignored.
- `in_port` in WIDTH — asynchronous external inputs.
- `readdata` out 32 — registered read data. Bits at or above WIDTH read 0.
- `irq` out 1 — level interrupt, equal to `|(edge_capture & irq_mask)`.

## Operation
- Register map. A write occurs when `chipselect && !write_n`.
  - Address 0, DATA (RO): filtered input value `stable`.
  - Address 1, RISE_EN (RW): per-bit rising-edge enable. Resets to all ones.
  - Address 2, IRQ_MASK (RW): resets to 0.
  - Address 3, EDGE_CAPTURE (R/W1C): resets to 0.
  - Address 4, FALL_EN (RW): per-bit falling-edge enable. Resets to 0.
  - Address 5, IRQ_PEND (RO): `edge_capture & irq_mask`.
  - Addresses 6–7 read 0; writes to them have no effect.
- Synchroniser: a per-channel shift register of SYNC_STAGES flops, reset to 0. Its output is `sync_out`.
- Debounce (when compiled in), per channel:
  - If `sync_out == stable`, the counter is set to 0.
  - Otherwise the counter increments. When a mismatch is seen with counter == DB_CYCLES-1, `stable` is loaded with `sync_out` and the counter is cleared.
  - Any glitch shorter than DB_CYCLES cycles never reaches `stable`.
  - Counter width is `$clog2(DB_CYCLES)`, minimum 1 bit. The counter never wraps.
- `prev` is `stable` delayed by one cycle, reset to 0.
- Edge detection:
  - `edge = (stable & ~prev & rise_en) | (~stable & prev & fall_en)`.
  - With both enables set for a bit, either edge is detected on that bit.
- Capture: `edge_capture[i]` is set on `edge[i]` and cleared by a write to address 3 with `writedata[i] = 1`. If a set and a clear occur in the same cycle, the set wins, so no event is lost.
- Changing RISE_EN or FALL_EN does not alter bits already captured.
- An input held at 1 through reset release produces one rising-edge capture, if RISE_EN is set for that bit.

## Timing
- Reset values: `readdata` = 0, `irq` = 0, and all internal state as listed above.
- `readdata` is registered every cycle from the current address, independent of `chipselect`. Read latency is 1.
- Register writes take effect at the clock edge of the write. Reads in the following cycle return the new value.
- Input-to-capture latency, with `in_port` changing before edge 0:
  - Without debounce: `edge_capture` is set at edge SYNC_STAGES+1.
  - With debounce: `edge_capture` is set at edge SYNC_STAGES+DB_CYCLES+1.
- `irq` is combinational from flops. It asserts in the same cycle the capture or mask flop changes, and deasserts in the cycle after a W1C write that clears the last pending bit.
- Asserting reset mid-debounce discards the partial count. No capture results from the aborted transition.

## Configuration
- `PIO_EDGE_IRQ_DEBOUNCE_EN`
  - Defined: the debounce counters are instantiated, with the latency stated above.
  - Undefined: `stable = sync_out` directly, no counters are generated, and DB_CYCLES is ignored.

## Structure
- Package `pio_edge_irq_pkg`: address constants (ADDR_DATA..ADDR_IRQ_PEND), the address width constant, and reset constants for RISE_EN and FALL_EN.
- Sub-module `pio_edge_irq_filter`: one channel of synchroniser plus optional debounce, with output `stable`. It is generated WIDTH times.
- The top level holds the registers, edge detection, capture logic and read mux.

## Test plan
- Reset with all `in_port` = 0, then read addresses 0–5.
  - Expect 0, 0xF, 0, 0, 0, 0; `irq` = 0.
- Debounce on, SYNC_STAGES=2, DB_CYCLES=4: raise `in_port[1]` for 3 cycles, then drop it.
  - Expect no capture.
  - Hold it high: `edge_capture` = 0x2 at edge 7.
  - Write IRQ_MASK = 0x2: `irq` = 1.
- Set FALL_EN = 0x1 and RISE_EN = 0x0, then pulse `in_port[0]` 0→1→0.
  - Expect only the falling edge captured, `edge_capture` = 0x1.
  - RISE_EN = FALL_EN = 0x8 with a toggling bit 3: both edges set bit 3.
- With captures 0xF and mask 0xF, write 0x5 to address 3.
  - Expect capture 0xA and `irq` still 1.
  - Write 0xA: `irq` drops the next cycle.
- Issue a W1C of bit 2 in the same cycle that `edge[2]` fires.
  - Expect bit 2 to remain 1.
- WIDTH=32, debounce undefined: toggle all inputs.
  - Expect `edge_capture` = 0xFFFFFFFF at edge 3; address 6 reads 0.
